// File: rtl/shift_burst_arbiter.sv
// Round-robin arbiter that streams a 1..MAX_LEN nibble burst into an external
// shift register, captures its output and returns it over a valid/ready channel.
module shift_burst_arbiter #(
   parameter int WIDTH   = 4,
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 3,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               req_valid,
   output logic [1:0]               req_ready,
   input  logic [MAX_LEN*WIDTH-1:0] req_data0,
   input  logic [LEN_W-1:0]         req_len0,
   input  logic [MAX_LEN*WIDTH-1:0] req_data1,
   input  logic [LEN_W-1:0]         req_len1,
   output logic                     sh_shift_en,
   output logic [WIDTH-1:0]         sh_data_in,
   input  logic [WIDTH-1:0]         sh_data_out,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic                     resp_id,
   output logic [WIDTH-1:0]         resp_data,
   output logic                     busy,
   output logic [CNT_W-1:0]         burst_count
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_RESP} state_t;

   state_t                     r_state, w_state_next;
   logic [MAX_LEN*WIDTH-1:0]   r_data, w_data_next;
   logic [LEN_W-1:0]           r_len, w_len_next;
   logic [LEN_W-1:0]           r_idx, w_idx_next;
   logic                       r_last_grant, w_last_grant_next;
   logic                       r_shift_en, w_shift_en_next;
   logic [WIDTH-1:0]           r_data_in, w_data_in_next;
   logic                       r_resp_valid, w_resp_valid_next;
   logic                       r_resp_id, w_resp_id_next;
   logic [WIDTH-1:0]           r_resp_data, w_resp_data_next;
   logic                       r_busy;
   logic [CNT_W-1:0]           r_burst_count, w_burst_count_next;

   logic                       w_sel;
   logic                       w_accept;
   logic [MAX_LEN*WIDTH-1:0]   w_sel_data;
   logic [LEN_W-1:0]           w_sel_len;
   logic [LEN_W-1:0]           w_idx_inc;
   logic [WIDTH-1:0]           w_held_nib [MAX_LEN];

   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_nib
         assign w_held_nib[gi] = r_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // On a tie the requester that did not win last time is chosen.
   assign w_sel      = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
   assign w_accept   = (r_state == S_IDLE) && (|req_valid);
   assign w_sel_data = w_sel ? req_data1 : req_data0;
   assign w_sel_len  = w_sel ? req_len1 : req_len0;
   assign w_idx_inc  = r_idx + LEN_W'(1);
   assign req_ready  = w_accept ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

   always_comb begin
      w_state_next       = r_state;
      w_data_next        = r_data;
      w_len_next         = r_len;
      w_idx_next         = r_idx;
      w_last_grant_next  = r_last_grant;
      w_shift_en_next    = 1'b0;
      w_data_in_next     = '0;
      w_resp_valid_next  = r_resp_valid;
      w_resp_id_next     = r_resp_id;
      w_resp_data_next   = r_resp_data;
      w_burst_count_next = r_burst_count;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next      = S_SHIFT;
               w_data_next       = w_sel_data;
               w_len_next        = w_sel_len;
               w_idx_next        = '0;
               w_last_grant_next = w_sel;
               w_resp_id_next    = w_sel;
               w_shift_en_next   = 1'b1;
               w_data_in_next    = w_sel_data[WIDTH-1:0];
            end
         end
         S_SHIFT: begin
            // Outputs are registered, so this cycle prepares the next nibble.
            if (r_idx == r_len) begin
               w_state_next = S_CAPTURE;
            end else begin
               w_idx_next      = w_idx_inc;
               w_shift_en_next = 1'b1;
               w_data_in_next  = w_held_nib[w_idx_inc];
            end
         end
         S_CAPTURE: begin
            w_state_next      = S_RESP;
            w_resp_data_next  = sh_data_out;
            w_resp_valid_next = 1'b1;
         end
         S_RESP: begin
            if (resp_ready) begin
               w_state_next       = S_IDLE;
               w_resp_valid_next  = 1'b0;
               w_burst_count_next = r_burst_count + CNT_W'(1);
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_data        <= '0;
         r_len         <= '0;
         r_idx         <= '0;
         r_last_grant  <= 1'b1;
         r_shift_en    <= 1'b0;
         r_data_in     <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_id     <= 1'b0;
         r_resp_data   <= '0;
         r_busy        <= 1'b0;
         r_burst_count <= '0;
      end else begin
         r_state       <= w_state_next;
         r_data        <= w_data_next;
         r_len         <= w_len_next;
         r_idx         <= w_idx_next;
         r_last_grant  <= w_last_grant_next;
         r_shift_en    <= w_shift_en_next;
         r_data_in     <= w_data_in_next;
         r_resp_valid  <= w_resp_valid_next;
         r_resp_id     <= w_resp_id_next;
         r_resp_data   <= w_resp_data_next;
         r_busy        <= (w_state_next != S_IDLE);
         r_burst_count <= w_burst_count_next;
      end
   end

   assign sh_shift_en = r_shift_en;
   assign sh_data_in  = r_data_in;
   assign resp_valid  = r_resp_valid;
   assign resp_id     = r_resp_id;
   assign resp_data   = r_resp_data;
   assign busy        = r_busy;
   assign burst_count = r_burst_count;

endmodule

// File: tb/tb_shift_burst_arbiter.sv
// Directed and random bursts checked against a transaction-level model of the
// arbiter; a narrow counter instance makes the wrap-around reachable quickly.
module tb_shift_burst_arbiter;

   localparam int WIDTH   = 4;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 3;
   localparam int CNT_W   = 6;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [1:0]               req_valid;
   logic [1:0]               req_ready;
   logic [MAX_LEN*WIDTH-1:0] req_data0, req_data1;
   logic [LEN_W-1:0]         req_len0, req_len1;
   logic                     sh_shift_en;
   logic [WIDTH-1:0]         sh_data_in;
   logic [WIDTH-1:0]         sh_q = '0;
   logic                     resp_valid;
   logic                     resp_ready;
   logic                     resp_id;
   logic [WIDTH-1:0]         resp_data;
   logic                     busy;
   logic [CNT_W-1:0]         burst_count;

   int total = 0;
   int bad   = 0;
   int exp_last;
   int exp_count;

   shift_burst_arbiter #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data0(req_data0), .req_len0(req_len0),
      .req_data1(req_data1), .req_len1(req_len1),
      .sh_shift_en(sh_shift_en), .sh_data_in(sh_data_in), .sh_data_out(sh_q),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .busy(busy), .burst_count(burst_count)
   );

   always #5 clk = ~clk;

   // Downstream shift register: loads on enabled edges, holds otherwise.
   always @(posedge clk) if (sh_shift_en) sh_q <= sh_data_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
         $error("check %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: arbitration, shifts, capture, stalled response.
   task automatic do_burst(input logic [1:0] v, input logic [31:0] d0, input logic [2:0] l0,
                           input logic [31:0] d1, input logic [2:0] l1,
                           input int rdelay, input int abort_at);
      int g;
      int len;
      logic [31:0] d;
      req_valid = v; req_data0 = d0; req_len0 = l0; req_data1 = d1; req_len1 = l1;
      #1;
      if (v == 2'b11) g = 1 - exp_last;
      else            g = v[1] ? 1 : 0;
      d   = (g == 1) ? d1 : d0;
      len = (g == 1) ? int'(l1) : int'(l0);
      chk("req_ready", 32'(req_ready), (g == 1) ? 32'd2 : 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      step();
      exp_last = g;
      req_data0 = $urandom; req_data1 = $urandom;
      req_len0 = 3'($urandom_range(0, 7)); req_len1 = 3'($urandom_range(0, 7));
      for (int k = 0; k <= len; k++) begin
         if (k == abort_at) begin
            reset = 1'b1;
            step();
            chk("rst_shift_en", 32'(sh_shift_en), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_count", 32'(burst_count), 32'd0);
            reset = 1'b0;
            exp_last = 1;
            exp_count = 0;
            $display("burst g=%0d len=%0d aborted by reset at shift %0d", g, len, k);
            return;
         end
         chk("shift_en", 32'(sh_shift_en), 32'd1);
         chk("shift_nib", 32'(sh_data_in), (d >> (4 * k)) & 32'hF);
         chk("shift_busy", 32'(busy), 32'd1);
         chk("shift_ready", 32'(req_ready), 32'd0);
         step();
      end
      chk("cap_shift_en", 32'(sh_shift_en), 32'd0);
      chk("cap_data_in", 32'(sh_data_in), 32'd0);
      chk("cap_resp_valid", 32'(resp_valid), 32'd0);
      step();
      for (int r = 0; r <= rdelay; r++) begin
         resp_ready = (r == rdelay);
         chk("resp_valid", 32'(resp_valid), 32'd1);
         chk("resp_id", 32'(resp_id), 32'(g));
         chk("resp_data", 32'(resp_data), (d >> (4 * len)) & 32'hF);
         chk("resp_ready_req", 32'(req_ready), 32'd0);
         chk("resp_count", 32'(burst_count), 32'(exp_count));
         chk("resp_busy", 32'(busy), 32'd1);
         step();
      end
      resp_ready = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      chk("done_valid", 32'(resp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_count", 32'(burst_count), 32'(exp_count));
      $display("burst g=%0d len=%0d data=%h resp=%h stall=%0d count=%0d",
               g, len, d, resp_data, rdelay, burst_count);
   endtask

   initial begin
      reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
      req_data0 = '0; req_data1 = '0; req_len0 = '0; req_len1 = '0;
      exp_last = 1; exp_count = 0;
      step();
      step();
      reset = 1'b0;
      chk("reset_shift_en", 32'(sh_shift_en), 32'd0);
      chk("reset_data_in", 32'(sh_data_in), 32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_id", 32'(resp_id), 32'd0);
      chk("reset_resp_data", 32'(resp_data), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_count", 32'(burst_count), 32'd0);

      do_burst(2'b01, 32'h00000006, 3'd0, 32'h0, 3'd0, 0, -1);
      do_burst(2'b01, 32'h00000321, 3'd2, 32'h0, 3'd0, 0, -1);

      req_valid = 2'b00;
      #1;
      chk("idle_no_req", 32'(req_ready), 32'd0);
      step();
      chk("idle_stays", 32'(busy), 32'd0);

      for (int i = 0; i < 4; i++)
         do_burst(2'b11, 32'h0000000A, 3'd0, 32'h00000005, 3'd0, 0, -1);

      do_burst(2'b11, 32'h87654321, 3'd3, 32'hFEDCBA98, 3'd5, 5, -1);
      do_burst(2'b01, 32'h76543210, 3'd7, 32'h0, 3'd0, 0, 3);
      do_burst(2'b01, 32'hCAFEF00D, 3'd1, 32'h0, 3'd0, 1, -1);

      for (int i = 0; i < 150; i++)
         do_burst(2'($urandom_range(1, 3)), $urandom, 3'($urandom_range(0, 7)),
                  $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_burst_arbiter.md
Name: shift_burst_arbiter

Overview:
Controller that shares one 4-bit shift register datapath (shiftEnable/dataIn in, dataOut back) between two requesters. It arbitrates round-robin and sequences a burst of 1..MAX_LEN nibbles into the register, one nibble per cycle. After the final shift it captures the register output and returns it to the winning requester over a valid/ready response channel. It sits between the requester logic and the ShiftRegister instance, which it owns exclusively.

Parameters:
WIDTH, 4, nibble width; equals the shift register data width.
MAX_LEN, 8, maximum nibbles per burst.
LEN_W, 3, width of the length field; encodes burst length minus one (clog2(MAX_LEN)).
CNT_W, 16, width of the completed-burst counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  2  per-requester burst request; bit i belongs to requester i.
req_ready  output  2  per-requester accept; combinational; at most one bit high.
req_data0  input  MAX_LEN*WIDTH  requester 0 burst payload; nibble 0 in bits [WIDTH-1:0].
req_len0  input  LEN_W  requester 0 burst length minus one.
req_data1  input  MAX_LEN*WIDTH  requester 1 burst payload.
req_len1  input  LEN_W  requester 1 burst length minus one.
sh_shift_en  output  1  drives ShiftRegister shiftEnable.
sh_data_in  output  WIDTH  drives ShiftRegister dataIn.
sh_data_out  input  WIDTH  ShiftRegister dataOut.
resp_valid  output  1  response available.
resp_ready  input  1  response consumer ready.
resp_id  output  1  index of the requester that owns the response.
resp_data  output  WIDTH  captured sh_data_out.
busy  output  1  high in any state other than IDLE.
burst_count  output  CNT_W  number of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous): state is IDLE, and all registered outputs are 0 (sh_shift_en, sh_data_in, resp_valid, resp_id, resp_data, busy, burst_count). last_grant is set to 1, so requester 0 wins the first tie. Reset overrides everything, including a burst in progress. The shift register receives sh_shift_en=0 from the cycle after the reset edge.
- Downstream contract: ShiftRegister loads dataIn into dataOut on the rising edge where shiftEnable=1. dataOut holds its value when shiftEnable=0.
- Arbitration (IDLE only): let g be the selected requester.
  - If only one req_valid bit is set, g is that requester.
  - If both are set, g = ~last_grant.
  - req_ready[g]=1 combinationally. The handshake occurs on req_valid[g] & req_ready[g].
  - req_ready is 0 in every other state.
- Accept edge: latch data, len and id=g; set last_grant=g and idx=0; go to SHIFT.
- SHIFT state:
  - Each cycle: sh_shift_en=1, sh_data_in = nibble[idx].
  - idx increments each cycle. When idx==len, go to CAPTURE next.
  - Exactly len+1 shift cycles; nibbles are sent in order 0..len.
- CAPTURE state: sh_shift_en=0, sh_data_in=0. On the edge, resp_data <= sh_data_out, resp_valid <= 1; go to RESP.
- RESP state:
  - resp_valid stays high; resp_id and resp_data are held stable until resp_valid & resp_ready.
  - On that edge: resp_valid <= 0, burst_count += 1 (wraps), go to IDLE.
  - No new request is accepted in the same cycle.
- Latency: with acceptance at edge T0, shifts occupy cycles T0+1..T0+len+1, CAPTURE is T0+len+2, and resp_valid is first seen in cycle T0+len+3.
- busy is registered from the state: 1 from the cycle after acceptance until the cycle after the response handshake.
- Request inputs are ignored outside the accept edge. A change to req_data or req_len mid-burst has no effect.
- A requester holding req_valid across a response is served again only after the other requester has been served, if the other is pending.

Test Plan:
- After reset: req_valid=01, req_len0=0, req_data0=...6 → req_ready=01 in cycle 0; one cycle with sh_shift_en=1, sh_data_in=6; resp_valid rises 3 cycles after accept with resp_data=6, resp_id=0; burst_count=1 after the handshake.
- req_valid=01, req_len0=2, req_data0=0x00000321 → sh_data_in sequence 1,2,3 on 3 consecutive cycles with sh_shift_en=1; resp_data=3.
- Both requesters valid continuously from reset, len=0, data 0xA and 0x5 → grants alternate 0,1,0,1; resp_id sequence 0,1,0,1 with resp_data A,5,A,5.
- resp_ready=0 for 5 cycles while req_valid=11 → resp_valid, resp_id and resp_data stable; req_ready=00 throughout; burst_count unchanged until resp_ready=1.
- reset=1 during the 4th shift of a len=7 burst → next cycle sh_shift_en=0, busy=0, resp_valid=0, burst_count=0; next request gets nibble 0 first.
- Preload burst_count to 0xFFFF (force, or 65535 bursts) → after the next handshake burst_count=0x0000.
